// File: rtl/dom_sbox_issue_sched.sv
// Issue scheduler for a non-stallable pipelined DOM masked AES S-box: pairs shared
// bytes with fresh randomness, tracks in-flight slots and collects results under credit.
module dom_sbox_issue_sched #(
  parameter int SHARES     = 2,
  parameter int LATENCY    = 5,
  parameter int RND_BITS   = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  ClkxCI,
  input  logic                  RstxRI,
  input  logic                  InValidxSI,
  output logic                  InReadyxSO,
  input  logic [8*SHARES-1:0]   InDataxDI,
  input  logic                  InLastxSI,
  input  logic                  RndValidxSI,
  output logic                  RndReadyxSO,
  input  logic [RND_BITS-1:0]   RndxDI,
  output logic                  SboxEnxSO,
  output logic [8*SHARES-1:0]   SboxInxDO,
  output logic [RND_BITS-1:0]   SboxRndxDO,
  input  logic [8*SHARES-1:0]   SboxOutxDI,
  output logic                  OutValidxSO,
  input  logic                  OutReadyxSI,
  output logic [8*SHARES-1:0]   OutDataxDO,
  output logic                  OutLastxSO,
  output logic                  BusyxSO,
  output logic                  DonexSO
);
  localparam int DW = 8*SHARES;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             r_state;
  logic               r_done;
  logic [LATENCY-1:0] r_tag_vld_p;
  logic [LATENCY-1:0] r_tag_last_p;
  logic [LATENCY-1:0] w_tag_vld_nxt;
  logic [LATENCY-1:0] w_tag_last_nxt;
  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_inflight;
  logic [CW-1:0]      w_used;
  logic               w_can_issue;
  logic               w_fire;
  logic               w_push;
  logic               w_pop;

  // Credit: every slot in the S-box pipe already owns a FIFO entry.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LATENCY; k++) w_inflight = w_inflight + CW'(r_tag_vld_p[k]);
    w_used = w_inflight + r_cnt;
  end

  assign w_can_issue = !RstxRI && (r_state != DRAIN) && RndValidxSI &&
                       (w_used < CW'(FIFO_DEPTH));
  assign w_fire      = InValidxSI && w_can_issue;

  always_comb begin
    w_tag_vld_nxt     = r_tag_vld_p << 1;
    w_tag_last_nxt    = r_tag_last_p << 1;
    w_tag_vld_nxt[0]  = w_fire;
    w_tag_last_nxt[0] = w_fire && InLastxSI;
  end

  assign w_push = r_tag_vld_p[LATENCY-1] && !RstxRI;
  assign w_pop  = OutReadyxSI && (r_cnt != '0);

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_tag_vld_p <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
    end else begin
      r_tag_vld_p <= w_tag_vld_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_done <= 1'b0;
      case (r_state)
        IDLE:  if (w_fire) r_state <= InLastxSI ? DRAIN : RUN;
        RUN:   if (w_fire && InLastxSI) r_state <= DRAIN;
        DRAIN: begin
          // Done is raised the cycle after the final slot lands in the FIFO.
          if (r_done) r_state <= IDLE;
          else if (w_tag_vld_nxt == '0) r_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ClkxCI) begin
    r_tag_last_p <= w_tag_last_nxt;
    if (w_push) begin
      r_mem[r_wptr]      <= SboxOutxDI;
      r_mem_last[r_wptr] <= r_tag_last_p[LATENCY-1];
    end
  end

  assign InReadyxSO  = w_can_issue;
  assign RndReadyxSO = w_fire;
  assign SboxEnxSO   = w_fire;
  assign SboxInxDO   = w_fire ? InDataxDI : '0;
  assign SboxRndxDO  = w_fire ? RndxDI : '0;
  assign OutValidxSO = (r_cnt != '0);
  assign OutDataxDO  = OutValidxSO ? r_mem[r_rptr] : '0;
  assign OutLastxSO  = OutValidxSO && r_mem_last[r_rptr];
  assign BusyxSO     = (r_state != IDLE);
  assign DonexSO     = r_done;

  a_no_overflow: assert property (@(posedge ClkxCI) disable iff (RstxRI)
    !(w_push && (r_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dom_sbox_issue_sched.sv
// Randomized bench for dom_sbox_issue_sched: emulates a masked S-box pipeline and
// checks every cycle against a queue-based job/credit model plus literal scenario checks.
module tb_dom_sbox_issue_sched;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        RstxRI = 1'b1;
  logic        InValidxSI = 1'b0;
  logic        InReadyxSO;
  logic [15:0] InDataxDI = '0;
  logic        InLastxSI = 1'b0;
  logic        RndValidxSI = 1'b0;
  logic        RndReadyxSO;
  logic [17:0] RndxDI = '0;
  logic        SboxEnxSO;
  logic [15:0] SboxInxDO;
  logic [17:0] SboxRndxDO;
  logic [15:0] SboxOutxDI = '0;
  logic        OutValidxSO;
  logic        OutReadyxSI = 1'b0;
  logic [15:0] OutDataxDO;
  logic        OutLastxSO;
  logic        BusyxSO;
  logic        DonexSO;

  dom_sbox_issue_sched #(.SHARES(2), .LATENCY(LAT), .RND_BITS(18), .FIFO_DEPTH(DEPTH)) dut (
    .ClkxCI(clk), .RstxRI(RstxRI),
    .InValidxSI(InValidxSI), .InReadyxSO(InReadyxSO), .InDataxDI(InDataxDI), .InLastxSI(InLastxSI),
    .RndValidxSI(RndValidxSI), .RndReadyxSO(RndReadyxSO), .RndxDI(RndxDI),
    .SboxEnxSO(SboxEnxSO), .SboxInxDO(SboxInxDO), .SboxRndxDO(SboxRndxDO), .SboxOutxDI(SboxOutxDI),
    .OutValidxSO(OutValidxSO), .OutReadyxSI(OutReadyxSI), .OutDataxDO(OutDataxDO),
    .OutLastxSO(OutLastxSO), .BusyxSO(BusyxSO), .DonexSO(DonexSO)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [15:0] res; logic last; } ent_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;
  logic [7:0]  sbox_tab [256];
  logic        emu_vld [64];
  logic [15:0] emu_out [64];
  ent_t infl[$];
  ent_t fifo[$];
  ent_t dut_pop[$];
  logic [15:0] preset[$];
  bit   in_job = 0, draining = 0, have_byte = 0;
  int   done_cyc = -1;
  int   job_len = 0, job_idx = 0;
  logic [15:0] cur_data = '0;
  logic        cur_last = 1'b0;
  logic log_fire [256], log_ov [256], log_done [256], log_busy [256], log_inrdy [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // AES S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [15:0] masked_sbox(input logic [15:0] s, input logic [17:0] r);
    logic [7:0] m;
    m = r[7:0] ^ r[17:10];
    return {m, sbox_tab[s[7:0] ^ s[15:8]] ^ m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] next_data();
    if (preset.size() > 0) return preset.pop_front();
    return 16'($urandom);
  endfunction

  task automatic start_job(input int len);
    job_len = len; job_idx = 0; have_byte = 1;
    cur_data = next_data(); cur_last = (len == 1);
  endtask

  task automatic step(input bit iv, input bit rv, input bit orr, input bit rst);
    logic [17:0] rnd;
    logic [15:0] din;
    logic        dlast;
    bit          exp_fire;
    int          used, rel;
    ent_t        e;
    @(negedge clk);
    din = cur_data; dlast = cur_last; rnd = 18'($urandom);
    RstxRI = rst; InValidxSI = iv && have_byte; InDataxDI = din; InLastxSI = dlast;
    RndValidxSI = rv; RndxDI = rnd; OutReadyxSI = orr;
    if (cyc >= LAT && emu_vld[(cyc - LAT) % 64]) SboxOutxDI = emu_out[(cyc - LAT) % 64];
    else SboxOutxDI = 16'($urandom);
    #1;
    emu_vld[cyc % 64] = SboxEnxSO;
    emu_out[cyc % 64] = masked_sbox(SboxInxDO, SboxRndxDO);
    rel = cyc - base;
    if (rel >= 0 && rel < 256) begin
      log_fire[rel] = SboxEnxSO; log_ov[rel] = OutValidxSO; log_done[rel] = DonexSO;
      log_busy[rel] = BusyxSO; log_inrdy[rel] = InReadyxSO;
    end
    if (OutValidxSO && orr && !rst) begin
      e.cyc = cyc; e.res = OutDataxDO; e.last = OutLastxSO;
      dut_pop.push_back(e);
    end
    if (rst) begin
      infl.delete(); fifo.delete();
      in_job = 0; draining = 0; done_cyc = -1; have_byte = 0;
    end else begin
      used = infl.size() + fifo.size();
      exp_fire = iv && have_byte && !draining && rv && (used < DEPTH);
      chk("in_ready",  InReadyxSO,  32'(!draining && rv && (used < DEPTH)));
      chk("rnd_ready", RndReadyxSO, 32'(exp_fire));
      chk("sbox_en",   SboxEnxSO,   32'(exp_fire));
      chk("sbox_in",   SboxInxDO,   exp_fire ? 32'(din) : 32'h0);
      chk("sbox_rnd",  SboxRndxDO,  exp_fire ? 32'(rnd) : 32'h0);
      chk("out_valid", OutValidxSO, 32'(fifo.size() > 0));
      chk("out_data",  OutDataxDO,  fifo.size() > 0 ? 32'(fifo[0].res) : 32'h0);
      chk("out_last",  OutLastxSO,  fifo.size() > 0 ? 32'(fifo[0].last) : 32'h0);
      chk("busy",      BusyxSO,     32'(in_job));
      chk("done",      DonexSO,     32'(cyc == done_cyc));
      if (orr && fifo.size() > 0) void'(fifo.pop_front());
      if (infl.size() > 0 && infl[0].cyc == cyc - LAT) fifo.push_back(infl.pop_front());
      if (cyc == done_cyc) begin
        in_job = 0; draining = 0;
      end else if (draining && infl.size() == 0 && done_cyc < cyc) begin
        done_cyc = cyc + 1;
      end
      if (exp_fire) begin
        e.cyc = cyc; e.res = masked_sbox(din, rnd); e.last = dlast;
        infl.push_back(e);
        in_job = 1;
        if (dlast) draining = 1;
        job_idx++;
        if (job_idx == job_len) have_byte = 0;
        else begin
          cur_data = next_data(); cur_last = (job_idx == job_len - 1);
        end
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((in_job || infl.size() > 0 || fifo.size() > 0) && n < 200) begin
      step(0, 1, 1, 0); n++;
    end
    chk("drain_bound", 32'(n >= 200), 32'h0);
  endtask

  task automatic feed_all(input bit rv, input bit orr);
    int n;
    n = 0;
    while (have_byte && n < 300) begin step(1, rv, orr, 0); n++; end
    chk("feed_bound", 32'(n >= 300), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {InReadyxSO, RndReadyxSO, SboxEnxSO, OutValidxSO, OutLastxSO, BusyxSO, DonexSO}, 32'h0);
    chk({tag, "_sbin"}, {SboxInxDO, OutDataxDO}, 32'h0);
    chk({tag, "_sbrnd"}, SboxRndxDO, 32'h0);
  endtask

  task automatic new_scenario();
    base = cyc; dut_pop.delete();
    for (int i = 0; i < 256; i++) begin
      log_fire[i] = 0; log_ov[i] = 0; log_done[i] = 0; log_busy[i] = 0; log_inrdy[i] = 0;
    end
  endtask

  initial begin
    int cnt, first_ov;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first_ov;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    for (int i = 0; i < 64; i++) begin emu_vld[i] = 0; emu_out[i] = '0; end
    chk("sbox_00", sbox_tab[8'h00], 32'h63);
    chk("sbox_53", sbox_tab[8'h53], 32'hED);
    chk("sbox_01", sbox_tab[8'h01], 32'h7C);

    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_all_zero("reset");

    // Back-to-back 16 bytes
    new_scenario();
    preset.push_back(16'hA5A5); preset.push_back(16'h4013);
    start_job(16);
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0);
    drain();
    cnt = 0; first_ov = -1;
    for (int i = 0; i < 16; i++) cnt += int'(log_fire[i]);
    chk("b2b_fires", cnt, 16);
    for (int i = 255; i >= 0; i--) if (log_ov[i]) first_ov = i;
    chk("b2b_first_ov", first_ov, 6);
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(log_done[i]);
    chk("b2b_done_cnt", cnt, 1);
    chk("b2b_popcnt", dut_pop.size(), 16);
    chk("b2b_sbox_00", dut_pop[0].res[7:0] ^ dut_pop[0].res[15:8], 32'h63);
    chk("b2b_sbox_53", dut_pop[1].res[7:0] ^ dut_pop[1].res[15:8], 32'hED);

    // Randomness starvation
    new_scenario();
    start_job(12);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0);
      chk("starve_inready", InReadyxSO, 0);
      chk("starve_sboxen", SboxEnxSO, 0);
      chk("starve_sboxin", SboxInxDO, 0);
    end
    feed_all(1, 1);
    drain();
    chk("starve_popcnt", dut_pop.size(), 12);

    // Backpressure
    new_scenario();
    start_job(30);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) cnt += int'(log_fire[i]);
    chk("bp_fires", cnt, 8);
    chk("bp_inready", InReadyxSO, 0);
    feed_all(1, 1);
    drain();
    chk("bp_popcnt", dut_pop.size(), 30);

    // Last on byte 3 and drain
    new_scenario();
    start_job(4);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0);
    chk("last_inready4", log_inrdy[4], 0);
    chk("last_done8", log_done[8], 0);
    chk("last_done9", log_done[9], 1);
    chk("last_busy9", log_busy[9], 1);
    chk("last_busy10", log_busy[10], 0);
    cnt = 0;
    for (int i = 0; i < dut_pop.size(); i++) cnt += int'(dut_pop[i].last);
    chk("last_cnt", cnt, 1);
    chk("last_on_b3", dut_pop[3].last, 1);
    drain();

    // Reset mid-job: 4 in flight, 2 in FIFO
    new_scenario();
    start_job(20);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst_fifo_cnt", fifo.size(), 2);
    chk("rst_infl_cnt", infl.size(), 4);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_all_zero("rst_mid");
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0);
      chk("rst_no_stale", OutValidxSO, 0);
    end

    // Simultaneous push/pop with one entry, across pointer wrap
    new_scenario();
    start_job(24);
    for (int i = 0; i < 24; i++) step(1, 1, 1, 0);
    drain();
    cnt = 0;
    for (int i = 6; i <= 28; i++) cnt += int'(log_ov[i]);
    chk("pp_ov_run", cnt, 23);
    chk("pp_popcnt", dut_pop.size(), 24);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!have_byte && ($urandom % 4 == 0)) start_job(1 + int'($urandom % 12));
      step($urandom % 4 != 0, $urandom % 5 != 0, $urandom % 3 != 0, $urandom % 600 == 0);
    end
    have_byte = 0;
    if (in_job && !draining) begin
      start_job(1);
      feed_all(1, 1);
    end
    drain();
    chk("final_idle", BusyxSO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
